command_dispatcher: RTL
=======================

// Module: command_dispatcher
// PURPOSE
//  Sequences the work behind each host frame decoded by the serial input handler ("L",cmd,size,data).
//  On each frame: latches command/buffer, drives the hash core through a nonce search loop, and emits
//  an ASCII response frame ('L', cmd char, optional hex nibbles) through a valid/ready byte sink.
// PARAMETERS
//  WORK_W    256    work/header bits, equal to the handler buffer width (BUFFER_SIZE+1)
//  NONCE_W   32     nonce counter width
//  WORK_NIB  64     data_count required for CMD_LOAD (WORK_W/4)
//  CHAR_BASE 8'h30  ASCII '0'; a nibble n is sent as CHAR_BASE+n (0x30..0x3F)
// PORTS
//  clk         in   1        system clock
//  rst         in   1        asynchronous active-high reset
//  cmd_ready   in   1        frame-complete strobe from the input handler; rising edge = new frame
//  command     in   4        decoded command, valid while cmd_ready is high
//  data_count  in   16       nibble count of frame payload
//  buffer      in   WORK_W   payload nibbles, last received nibble in [3:0]
//  hash_start  out  1        one-cycle pulse: hash {work, nonce}
//  hash_work   out  WORK_W   latched work register
//  hash_nonce  out  NONCE_W  nonce under test
//  hash_done   in   1        one-cycle pulse: result valid
//  hash_match  in   1        digest meets target, sampled with hash_done
//  tx_byte     out  8        response byte
//  tx_valid    out  1        tx_byte valid; holds until accepted
//  tx_ready    in   1        sink accepts when tx_valid&tx_ready at posedge
//  busy        out  1        high in any state except IDLE
//  mining      out  1        high while the search loop is active
// BEHAVIOUR
//  Reset: every output 0, work=0, nonce=0, state IDLE. Async assert; work resumes on the first edge after release.
//  Frame detect: a registered edge on cmd_ready. A 1-cycle pulse is sufficient.
//  Commands:
//   0 PING   -> resp "L0"
//   1 LOAD   -> data_count==WORK_NIB: work<=buffer, resp "L1"; otherwise work unchanged, resp "LE"
//   2 MINE   -> nonce<=0, enter search loop
//   3 STOP   -> resp "L3"; an active search is aborted
//   4 STATUS -> resp "L4"+8 nonce nibbles, MSB first
//   5..15    -> resp "LE"
//  FSM states: IDLE, DECODE, HSTART, HWAIT, NEXT, RESP.
//   IDLE->DECODE on frame edge; command is latched.
//   DECODE->RESP for cmds 0,1,3,4,err; DECODE->HSTART for cmd 2.
//   HSTART: hash_start=1 for one cycle -> HWAIT.
//   HWAIT: on hash_done, match -> RESP "L2"+8 nonce nibbles (nonce that matched); else -> NEXT.
//   NEXT: nonce<=nonce+1 (mod 2^NONCE_W). If the new nonce==0 (wrapped) -> RESP "LF"; else -> HSTART.
//   RESP: serialize chars; after the last byte is accepted -> IDLE (mining=0).
//  Latency: frame edge to tx_valid of 'L' = 3 cycles for non-mining commands.
//  During search (HSTART/HWAIT/NEXT):
//   frame with cmd 3 -> abort at the next edge; pending hash_done is ignored; resp "L3"; nonce is kept.
//   frame with cmd 4 -> ignored. Any other frame -> ignored.
//  Frames arriving in DECODE/RESP are dropped; there is no queue.
//  Same-cycle hash_done and STOP edge: STOP wins and the match is discarded.
//  hash_done outside HWAIT is ignored. tx_byte/tx_valid are stable while tx_valid&!tx_ready.
//  Nonce nibbles are sent as CHAR_BASE+{nonce[31:28]} ... CHAR_BASE+{nonce[3:0]}.
// STRUCTURE
//  llb_cmd_pkg (shared with the input handler): CMD_PING..CMD_STATUS codes, CHAR_L=8'h4C,
//   CHAR_BASE, RESP_ERR='E', RESP_EXH='F', and the FSM state encoding.
//  Sub-module resp_serializer: loads {cmd char, nibble count 0..8, 32-bit payload}, emits 'L',
//   the cmd char, then the nibbles over valid/ready, and pulses done.
//  The parent owns the FSM, work/nonce registers and frame-edge detect.
// TESTING
//  1. PING pulse cmd_ready, command=0, tx_ready=1 -> bytes 0x4C,0x30, then busy=0.
//  2. LOAD data_count=0x40, buffer=256'hA5.. -> hash_work==buffer, resp 0x4C,0x31.
//     LOAD data_count=0x3F -> resp 0x4C,0x45, work unchanged.
//  3. MINE, model asserts match at nonce 5 -> exactly 6 hash_start pulses,
//     resp "L2"+"00000005" (0x30 x7, 0x35).
//  4. MINE, then STOP injected while in HWAIT with a concurrent hash_done&match ->
//     resp "L3" only, mining=0, no "L2".
//  5. NONCE_W=4 build, never match -> 16 hash_start pulses, then resp 0x4C,0x46.
//  6. tx_ready held low 10 cycles mid-response -> tx_byte stable; rst asserted mid-MINE ->
//     all outputs 0 asynchronously, IDLE.

Source files
------------

// File: rtl/llb_cmd_pkg.sv
// Command codes, response characters and FSM encoding shared by the frame
// handler and the dispatcher.
package llb_cmd_pkg;

    localparam logic [3:0] CMD_PING   = 4'd0;
    localparam logic [3:0] CMD_LOAD   = 4'd1;
    localparam logic [3:0] CMD_MINE   = 4'd2;
    localparam logic [3:0] CMD_STOP   = 4'd3;
    localparam logic [3:0] CMD_STATUS = 4'd4;

    localparam logic [7:0] CHAR_L    = 8'h4C;
    localparam logic [7:0] CHAR_BASE = 8'h30;
    localparam logic [7:0] RESP_ERR  = 8'h45;
    localparam logic [7:0] RESP_EXH  = 8'h46;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_HSTART,
        ST_HWAIT,
        ST_NEXT,
        ST_RESP
    } state_t;

    function automatic logic [7:0] nib_char(input logic [7:0] base, input logic [3:0] nib);
        return base + {4'h0, nib};
    endfunction

endpackage

// File: rtl/resp_serializer.sv
// Emits 'L', a command character and up to eight payload nibbles (MSB first)
// over a valid/ready byte interface, then pulses done.
module resp_serializer #(
    parameter logic [7:0] CHAR_BASE = llb_cmd_pkg::CHAR_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [7:0]  cmd_char,
    input  logic [3:0]  nib_count,
    input  logic [31:0] payload,
    input  logic        tx_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    output logic        done
);
    import llb_cmd_pkg::*;

    logic [7:0]  tx_byte_reg;
    logic        tx_valid_reg;
    logic        done_reg;
    logic [7:0]  cmd_char_reg;
    logic        cmd_pending_reg;
    logic [3:0]  nib_left_reg;
    logic [31:0] payload_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_byte_reg     <= 8'h00;
            tx_valid_reg    <= 1'b0;
            done_reg        <= 1'b0;
            cmd_char_reg    <= 8'h00;
            cmd_pending_reg <= 1'b0;
            nib_left_reg    <= 4'h0;
            payload_reg     <= 32'h0;
        end else begin
            done_reg <= 1'b0;
            if (load) begin
                tx_byte_reg     <= CHAR_L;
                tx_valid_reg    <= 1'b1;
                cmd_char_reg    <= cmd_char;
                cmd_pending_reg <= 1'b1;
                nib_left_reg    <= nib_count;
                payload_reg     <= payload;
            end else if (tx_valid_reg && tx_ready) begin
                // The byte on the bus was just taken; present the next one.
                if (cmd_pending_reg) begin
                    tx_byte_reg     <= cmd_char_reg;
                    cmd_pending_reg <= 1'b0;
                end else if (nib_left_reg != 4'h0) begin
                    tx_byte_reg  <= nib_char(CHAR_BASE, payload_reg[31:28]);
                    payload_reg  <= {payload_reg[27:0], 4'h0};
                    nib_left_reg <= nib_left_reg - 4'h1;
                end else begin
                    tx_byte_reg  <= 8'h00;
                    tx_valid_reg <= 1'b0;
                    done_reg     <= 1'b1;
                end
            end
        end
    end

    assign tx_byte  = tx_byte_reg;
    assign tx_valid = tx_valid_reg;
    assign done     = done_reg;

endmodule

// File: rtl/command_dispatcher.sv
// Runs each decoded host frame: latches work, drives the hash core through a
// nonce search and returns an ASCII response frame.
module command_dispatcher #(
    parameter int          WORK_W    = 256,
    parameter int          NONCE_W   = 32,
    parameter int          WORK_NIB  = 64,
    parameter logic [7:0]  CHAR_BASE = 8'h30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_ready,
    input  logic [3:0]         command,
    input  logic [15:0]        data_count,
    input  logic [WORK_W-1:0]  buffer,
    output logic               hash_start,
    output logic [WORK_W-1:0]  hash_work,
    output logic [NONCE_W-1:0] hash_nonce,
    input  logic               hash_done,
    input  logic               hash_match,
    output logic [7:0]         tx_byte,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               busy,
    output logic               mining
);
    import llb_cmd_pkg::*;

    state_t             state_reg;
    logic               cmd_ready_d_reg;
    logic [3:0]         cmd_reg;
    logic               load_ok_reg;
    logic [WORK_W-1:0]  work_reg;
    logic [NONCE_W-1:0] nonce_reg;
    logic               hash_start_reg;
    logic               ser_load_reg;
    logic [7:0]         ser_char_reg;
    logic [3:0]         ser_nib_reg;
    logic [31:0]        ser_payload_reg;
    logic               ser_done;

    logic               frame_rise;
    logic               searching;
    logic               stop_req;
    logic               count_ok;
    logic [NONCE_W-1:0] nonce_inc;

    assign frame_rise = cmd_ready && !cmd_ready_d_reg;
    assign searching  = (state_reg == ST_HSTART) || (state_reg == ST_HWAIT) ||
                        (state_reg == ST_NEXT);
    assign stop_req   = frame_rise && (command == CMD_STOP);
    assign count_ok   = (data_count == 16'(WORK_NIB));
    assign nonce_inc  = nonce_reg + NONCE_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            cmd_ready_d_reg <= 1'b0;
            cmd_reg         <= 4'h0;
            load_ok_reg     <= 1'b0;
            work_reg        <= '0;
            nonce_reg       <= '0;
            hash_start_reg  <= 1'b0;
            ser_load_reg    <= 1'b0;
            ser_char_reg    <= 8'h00;
            ser_nib_reg     <= 4'h0;
            ser_payload_reg <= 32'h0;
        end else begin
            cmd_ready_d_reg <= cmd_ready;
            hash_start_reg  <= 1'b0;
            ser_load_reg    <= 1'b0;
            ser_nib_reg     <= 4'h0;
            ser_payload_reg <= 32'(nonce_reg);

            // A STOP frame outranks anything the hash core reports this cycle.
            if (searching && stop_req) begin
                ser_char_reg <= nib_char(CHAR_BASE, CMD_STOP);
                ser_load_reg <= 1'b1;
                state_reg    <= ST_RESP;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (frame_rise) begin
                            cmd_reg     <= command;
                            load_ok_reg <= count_ok;
                            if (command == CMD_LOAD && count_ok)
                                work_reg <= buffer;
                            state_reg <= ST_DECODE;
                        end
                    end
                    ST_DECODE: begin
                        if (cmd_reg == CMD_MINE) begin
                            nonce_reg      <= '0;
                            hash_start_reg <= 1'b1;
                            state_reg      <= ST_HSTART;
                        end else begin
                            ser_load_reg <= 1'b1;
                            state_reg    <= ST_RESP;
                            case (cmd_reg)
                                CMD_PING:   ser_char_reg <= nib_char(CHAR_BASE, CMD_PING);
                                CMD_LOAD:   ser_char_reg <= load_ok_reg ?
                                                nib_char(CHAR_BASE, CMD_LOAD) : RESP_ERR;
                                CMD_STOP:   ser_char_reg <= nib_char(CHAR_BASE, CMD_STOP);
                                CMD_STATUS: begin
                                    ser_char_reg <= nib_char(CHAR_BASE, CMD_STATUS);
                                    ser_nib_reg  <= 4'd8;
                                end
                                default:    ser_char_reg <= RESP_ERR;
                            endcase
                        end
                    end
                    ST_HSTART: state_reg <= ST_HWAIT;
                    ST_HWAIT: begin
                        if (hash_done) begin
                            if (hash_match) begin
                                ser_char_reg <= nib_char(CHAR_BASE, CMD_MINE);
                                ser_nib_reg  <= 4'd8;
                                ser_load_reg <= 1'b1;
                                state_reg    <= ST_RESP;
                            end else begin
                                state_reg <= ST_NEXT;
                            end
                        end
                    end
                    ST_NEXT: begin
                        nonce_reg <= nonce_inc;
                        if (nonce_inc == '0) begin
                            ser_char_reg <= RESP_EXH;
                            ser_load_reg <= 1'b1;
                            state_reg    <= ST_RESP;
                        end else begin
                            hash_start_reg <= 1'b1;
                            state_reg      <= ST_HSTART;
                        end
                    end
                    ST_RESP: if (ser_done) state_reg <= ST_IDLE;
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    resp_serializer #(.CHAR_BASE(CHAR_BASE)) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load_reg),
        .cmd_char  (ser_char_reg),
        .nib_count (ser_nib_reg),
        .payload   (ser_payload_reg),
        .tx_ready  (tx_ready),
        .tx_byte   (tx_byte),
        .tx_valid  (tx_valid),
        .done      (ser_done)
    );

    assign hash_start = hash_start_reg;
    assign hash_work  = work_reg;
    assign hash_nonce = nonce_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign mining     = searching;

endmodule
